// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, row debounce, one key event per press, hex entry shift register.
// Key appears on key_code/key_valid the cycle after its event; a key arriving while one is unconsumed is dropped (overrun).
module keypad_scanner #(
  parameter int SCAN_DIV     = 100000,
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  input  logic        key_ready,
  output logic        key_down,
  output logic [31:0] value_out,
  output logic        overrun
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;

  state_t        state, state_nxt;
  logic [3:0]    row_meta, row_sync;
  logic [TW-1:0] timer;
  logic [1:0]    ci;
  logic [1:0]    cand_row;
  logic [1:0]    det_row;
  logic [1:0]    ev_row;
  logic [3:0]    ev_code;
  logic [CW-1:0] match_cnt;
  logic [CW-1:0] rel_cnt;
  logic          sample;
  logic          any_low;
  logic          cand_low;
  logic          key_event;
  logic          ci_adv;
  logic          load;
  logic          drop;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'b00_00: key_map = 4'h1;
      4'b00_01: key_map = 4'h2;
      4'b00_10: key_map = 4'h3;
      4'b00_11: key_map = 4'hA;
      4'b01_00: key_map = 4'h4;
      4'b01_01: key_map = 4'h5;
      4'b01_10: key_map = 4'h6;
      4'b01_11: key_map = 4'hB;
      4'b10_00: key_map = 4'h7;
      4'b10_01: key_map = 4'h8;
      4'b10_10: key_map = 4'h9;
      4'b10_11: key_map = 4'hC;
      4'b11_00: key_map = 4'h0;
      4'b11_01: key_map = 4'hF;
      4'b11_10: key_map = 4'hE;
      default:  key_map = 4'hD;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta <= 4'b1111;
      row_sync <= 4'b1111;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if (timer == TIMER_LAST) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  assign sample   = (timer == TIMER_LAST);
  assign any_low  = ~&row_sync;
  assign cand_low = ~row_sync[cand_row];
  assign col      = ~(4'b0001 << ci);

  // Lowest-index pressed row wins when several rows are low.
  always_comb begin
    det_row = 2'd3;
    if (!row_sync[0])      det_row = 2'd0;
    else if (!row_sync[1]) det_row = 2'd1;
    else if (!row_sync[2]) det_row = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= SCAN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SCAN: begin
        if (sample && any_low) state_nxt = (DEBOUNCE_CNT == 1) ? PRESSED : DEBOUNCE;
      end
      DEBOUNCE: begin
        if (sample) begin
          if (!cand_low)                  state_nxt = SCAN;
          else if (match_cnt == CNT_LAST) state_nxt = PRESSED;
        end
      end
      PRESSED: begin
        if (sample && !cand_low && rel_cnt == CNT_LAST) state_nxt = SCAN;
      end
      default: state_nxt = SCAN;
    endcase
  end

  // Every path back to SCAN (or staying there idle) happens on a sample and moves to the next column.
  always_comb begin
    key_down  = (state == PRESSED);
    key_event = (state != PRESSED) && (state_nxt == PRESSED);
    ci_adv    = sample && (state_nxt == SCAN);
    ev_row    = (state == SCAN) ? det_row : cand_row;
    ev_code   = key_map(ev_row, ci);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ci        <= 2'd0;
      cand_row  <= 2'd0;
      match_cnt <= '0;
      rel_cnt   <= '0;
    end else begin
      if (ci_adv) ci <= ci + 2'd1;
      case (state)
        SCAN: begin
          rel_cnt <= '0;
          if (sample && any_low) begin
            cand_row  <= det_row;
            match_cnt <= CW'(1);
          end
        end
        DEBOUNCE: begin
          if (sample) begin
            if (!cand_low || match_cnt == CNT_LAST) match_cnt <= '0;
            else                                    match_cnt <= match_cnt + CW'(1);
          end
        end
        PRESSED: begin
          match_cnt <= '0;
          if (sample) begin
            if (cand_low || rel_cnt == CNT_LAST) rel_cnt <= '0;
            else                                 rel_cnt <= rel_cnt + CW'(1);
          end
        end
        default: begin
          match_cnt <= '0;
          rel_cnt   <= '0;
        end
      endcase
    end
  end

  assign load = key_event && (!key_valid || key_ready);
  assign drop = key_event && key_valid && !key_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      value_out <= 32'h0;
      overrun   <= 1'b0;
    end else begin
      overrun <= drop;
      if (load) begin
        key_code  <= ev_code;
        key_valid <= 1'b1;
        value_out <= {value_out[27:0], ev_code};
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural key matrix driving row from col.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready = 1'b0;
  logic        key_down;
  logic [31:0] value_out;
  logic        overrun;

  logic [15:0] keys = 16'h0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          ovr_cnt = 0;
  int          ovr_base;
  int          hits;

  keypad_scanner #(.SCAN_DIV(8), .DEBOUNCE_CNT(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_down  (key_down),
    .value_out (value_out),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Pressed key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    for (int r = 0; r < 4; r++) row[r] = ~|(keys[r*4 +: 4] & ~col);
  end

  always @(negedge clk) if (overrun) ovr_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic press(input int r, input int c);
    keys = 16'h0;
    keys[r*4 + c] = 1'b1;
  endtask

  task automatic do_reset();
    keys = 16'h0;
    key_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int max);
    for (int i = 0; i < max && !key_valid; i++) @(negedge clk);
    check_eq(tag, {31'b0, key_valid}, 32'd1);
  endtask

  task automatic wait_down(input string tag, input logic lvl, input int max);
    for (int i = 0; i < max && key_down !== lvl; i++) @(negedge clk);
    check_eq(tag, {31'b0, key_down}, {31'b0, lvl});
  endtask

  initial begin
    // Reset values and idle column stepping
    do_reset();
    check_eq("rst_col", {28'b0, col}, 32'hE);
    check_eq("rst_valid", {31'b0, key_valid}, 32'd0);
    check_eq("rst_value", value_out, 32'h0);
    check_eq("rst_code", {28'b0, key_code}, 32'h0);
    check_eq("rst_down", {31'b0, key_down}, 32'd0);
    check_eq("rst_ovr", {31'b0, overrun}, 32'd0);
    repeat (7) @(negedge clk);
    check_eq("col_hold0", {28'b0, col}, 32'hE);
    @(negedge clk);
    check_eq("col_step1", {28'b0, col}, 32'hD);
    repeat (8) @(negedge clk);
    check_eq("col_step2", {28'b0, col}, 32'hB);
    repeat (8) @(negedge clk);
    check_eq("col_step3", {28'b0, col}, 32'h7);
    repeat (8) @(negedge clk);
    check_eq("col_wrap", {28'b0, col}, 32'hE);

    // Press key 8 (row 2, column 1): three samples in column 1, event at edge 31
    do_reset();
    press(2, 1);
    repeat (31) @(negedge clk);
    check_eq("p8_early", {31'b0, key_valid}, 32'd0);
    @(negedge clk);
    check_eq("p8_valid", {31'b0, key_valid}, 32'd1);
    check_eq("p8_code", {28'b0, key_code}, 32'h8);
    check_eq("p8_down", {31'b0, key_down}, 32'd1);
    check_eq("p8_col", {28'b0, col}, 32'hD);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    check_eq("p8_consumed", {31'b0, key_valid}, 32'd0);
    check_eq("p8_value", value_out, 32'h8);
    keys = 16'h0;
    wait_down("p8_release", 1'b0, 100);

    // Bounce: key 1 seen for two samples then released
    do_reset();
    press(0, 0);
    repeat (16) @(negedge clk);
    keys = 16'h0;
    check_eq("bnc_col_held", {28'b0, col}, 32'hE);
    repeat (7) @(negedge clk);
    check_eq("bnc_col_pre", {28'b0, col}, 32'hE);
    @(negedge clk);
    check_eq("bnc_col_adv", {28'b0, col}, 32'hD);
    check_eq("bnc_valid", {31'b0, key_valid}, 32'd0);
    check_eq("bnc_down", {31'b0, key_down}, 32'd0);
    repeat (8) @(negedge clk);
    check_eq("bnc_col_next", {28'b0, col}, 32'hB);
    check_eq("bnc_value", value_out, 32'h0);

    // Hold key 5 for 50 samples: a single event, then a second after release
    do_reset();
    press(1, 1);
    repeat (32) @(negedge clk);
    check_eq("h5_valid", {31'b0, key_valid}, 32'd1);
    check_eq("h5_code", {28'b0, key_code}, 32'h5);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    hits = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (key_valid || overrun) hits++;
    end
    check_eq("h5_no_repeat", hits, 32'd0);
    check_eq("h5_still_down", {31'b0, key_down}, 32'd1);
    keys = 16'h0;
    wait_down("h5_release", 1'b0, 100);
    press(1, 1);
    wait_valid("h5_second", 200);
    check_eq("h5_code2", {28'b0, key_code}, 32'h5);
    check_eq("h5_value", value_out, 32'h55);

    // Backpressure: key 2 dropped while key 1 pending, key 3 loaded with same-cycle ready
    do_reset();
    ovr_base = ovr_cnt;
    press(0, 0);
    repeat (23) @(negedge clk);
    check_eq("bp1_early", {31'b0, key_valid}, 32'd0);
    @(negedge clk);
    check_eq("bp1_valid", {31'b0, key_valid}, 32'd1);
    check_eq("bp1_code", {28'b0, key_code}, 32'h1);
    keys = 16'h0;
    wait_down("bp1_release", 1'b0, 100);
    press(0, 1);
    wait_down("bp2_press", 1'b1, 100);
    repeat (2) @(negedge clk);
    check_eq("bp2_code", {28'b0, key_code}, 32'h1);
    check_eq("bp2_value", value_out, 32'h1);
    check_eq("bp2_ovr", ovr_cnt - ovr_base, 32'd1);
    check_eq("bp2_valid", {31'b0, key_valid}, 32'd1);
    keys = 16'h0;
    wait_down("bp2_release", 1'b0, 100);
    check_eq("bp3_col", {28'b0, col}, 32'hB);
    press(0, 2);
    repeat (23) @(negedge clk);
    check_eq("bp3_pre_code", {28'b0, key_code}, 32'h1);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    check_eq("bp3_valid", {31'b0, key_valid}, 32'd1);
    check_eq("bp3_code", {28'b0, key_code}, 32'h3);
    check_eq("bp3_value", value_out, 32'h13);
    repeat (4) @(negedge clk);
    check_eq("bp3_ovr", ovr_cnt - ovr_base, 32'd1);

    // Reset after two matching samples, key kept held
    do_reset();
    press(0, 0);
    repeat (16) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rmd_col", {28'b0, col}, 32'hE);
    check_eq("rmd_valid", {31'b0, key_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (23) @(negedge clk);
    check_eq("rmd_early", {31'b0, key_valid}, 32'd0);
    @(negedge clk);
    check_eq("rmd_valid2", {31'b0, key_valid}, 32'd1);
    check_eq("rmd_code", {28'b0, key_code}, 32'h1);
    check_eq("rmd_value", value_out, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
